// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, jump, flush redirect and a circular
// return-address stack for call/return.
module pc_unit #(
    parameter int                 WIDTH        = 16,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int                 INC          = 1,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] flush_target,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_seq,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int               PTR_W   = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] INC_C   = WIDTH'(INC);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic             push;
    logic [PTR_W-1:0] pushIdx;

    assign pc_seq  = pc_q + INC_C;
    assign pushIdx = top_q + PTR_W'(1);

    // One request wins per edge: flush > stall > jump > call > ret > sequential.
    always_comb begin
        pc_d    = pc_seq;
        top_d   = top_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (flush) begin
            pc_d = flush_target;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (jump) begin
            pc_d = target;
        end else if (call) begin
            pc_d  = target;
            push  = 1'b1;
            top_d = pushIdx;
            if (count_q == DEPTH_C) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + (PTR_W + 1)'(1);
            end
        end else if (ret) begin
            if (count_q != '0) begin
                pc_d    = ras_q[top_q];
                top_d   = top_q - PTR_W'(1);
                count_d = count_q - (PTR_W + 1)'(1);
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_VECTOR;
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // When full, the push lands on the oldest entry since the pointer wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (push) begin
            ras_q[pushIdx] <= pc_seq;
        end
    end

    assign pc_out        = pc_q;
    assign ras_empty     = (count_q == '0);
    assign ras_full      = (count_q == DEPTH_C);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, async-reset sequence,
// and randomized traffic against a queue-based reference model.
module tb_pc_unit;

    logic        clock;
    logic        reset_n;
    logic        stall, flush, jump, call, ret;
    logic [15:0] flush_target, target;
    logic [15:0] pc_out, pc_seq;
    logic        ras_empty, ras_full, ras_overflow, ras_underflow;

    int total = 0;
    int bad   = 0;

    pc_unit #(
        .WIDTH(16), .RESET_VECTOR(16'h0100), .INC(1), .RAS_DEPTH(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
        .flush_target(flush_target), .jump(jump), .call(call), .ret(ret),
        .target(target), .pc_out(pc_out), .pc_seq(pc_seq),
        .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        fl, st, jp, cl, rt;
        logic [15:0] ft, tg;
        logic [15:0] pc;
        logic        em, fu, ov, un;
    } vec_t;

    vec_t vecs [36];

    // Reference model state: the stack is a plain queue, newest at the back.
    logic [15:0] mPc;
    logic [15:0] mRas [$];
    logic        mOvf, mUnf;

    function automatic vec_t mk(logic fl, logic st, logic jp, logic cl, logic rt,
                                logic [15:0] ft, logic [15:0] tg, logic [15:0] pc,
                                logic em, logic fu, logic ov, logic un);
        vec_t v;
        v.fl = fl; v.st = st; v.jp = jp; v.cl = cl; v.rt = rt;
        v.ft = ft; v.tg = tg; v.pc = pc;
        v.em = em; v.fu = fu; v.ov = ov; v.un = un;
        return v;
    endfunction

    // Drive one cycle of requests, let one rising edge pass, sample 1 ns later.
    task automatic applyStimulus(logic fl, logic st, logic jp, logic cl, logic rt,
                                 logic [15:0] ft, logic [15:0] tg);
        flush = fl; stall = st; jump = jp; call = cl; ret = rt;
        flush_target = ft; target = tg;
        @(posedge clock);
        #1;
        flush = 1'b0; stall = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    // Compare every output against the expected pc and stack status.
    task automatic checkOutput(string name, logic [15:0] pc, logic em, logic fu,
                               logic ov, logic un);
        logic [15:0] seq;
        logic [35:0] got, exp;
        seq = pc + 16'd1;
        got = {pc_out, pc_seq, ras_empty, ras_full, ras_overflow, ras_underflow};
        exp = {pc, seq, em, fu, ov, un};
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got pc=%h seq=%h e/f/o/u=%b%b%b%b, want pc=%h seq=%h e/f/o/u=%b%b%b%b",
                     name, pc_out, pc_seq, ras_empty, ras_full, ras_overflow, ras_underflow,
                     pc, seq, em, fu, ov, un);
        end
    endtask

    // Reference model: apply the priority rules to the queue-based stack.
    task automatic modelStep(logic fl, logic st, logic jp, logic cl, logic rt,
                             logic [15:0] ft, logic [15:0] tg);
        if (fl) begin
            mPc = ft;
        end else if (st) begin
            mPc = mPc;
        end else if (jp) begin
            mPc = tg;
        end else if (cl) begin
            mRas.push_back(mPc + 16'd1);
            if (mRas.size() > 4) begin
                void'(mRas.pop_front());
                mOvf = 1'b1;
            end
            mPc = tg;
        end else if (rt) begin
            if (mRas.size() > 0) begin
                mPc = mRas.pop_back();
            end else begin
                mPc  = mPc + 16'd1;
                mUnf = 1'b1;
            end
        end else begin
            mPc = mPc + 16'd1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        {flush, stall, jump, call, ret} = '0;
        flush_target = '0;
        target = '0;

        //                fl st jp cl rt  ft       tg       pc      em fu ov un
        vecs[0]  = mk(0, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0101, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0102, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0103, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0104, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 1, 0, 0, 16'h0, 16'hFFFE, 16'hFFFE, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 16'h0, 16'h0,    16'hFFFF, 1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0000, 1, 0, 0, 0);
        vecs[7]  = mk(0, 1, 0, 0, 0, 16'h0, 16'h0,    16'h0000, 1, 0, 0, 0);
        vecs[8]  = mk(0, 1, 0, 0, 0, 16'h0, 16'h0,    16'h0000, 1, 0, 0, 0);
        vecs[9]  = mk(0, 1, 1, 0, 0, 16'h0, 16'h1234, 16'h0000, 1, 0, 0, 0);
        vecs[10] = mk(1, 1, 0, 0, 0, 16'h0040, 16'h0, 16'h0040, 1, 0, 0, 0);
        vecs[11] = mk(0, 0, 1, 0, 0, 16'h0, 16'h0010, 16'h0010, 1, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 1, 0, 16'h0, 16'h0200, 16'h0200, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0201, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0202, 0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 1, 0, 16'h0, 16'h0300, 16'h0300, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 1, 16'h0, 16'h0,    16'h0203, 0, 0, 0, 0);
        vecs[17] = mk(0, 0, 0, 0, 1, 16'h0, 16'h0,    16'h0011, 1, 0, 0, 0);
        vecs[18] = mk(0, 0, 1, 0, 0, 16'h0, 16'h0A00, 16'h0A00, 1, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 1, 0, 16'h0, 16'h0B00, 16'h0B00, 0, 0, 0, 0);
        vecs[20] = mk(0, 0, 0, 1, 0, 16'h0, 16'h0C00, 16'h0C00, 0, 0, 0, 0);
        vecs[21] = mk(0, 0, 0, 1, 0, 16'h0, 16'h0D00, 16'h0D00, 0, 0, 0, 0);
        vecs[22] = mk(0, 0, 0, 1, 0, 16'h0, 16'h0E00, 16'h0E00, 0, 1, 0, 0);
        vecs[23] = mk(0, 0, 0, 1, 0, 16'h0, 16'h0F00, 16'h0F00, 0, 1, 1, 0);
        vecs[24] = mk(0, 0, 0, 0, 1, 16'h0, 16'h0,    16'h0E01, 0, 0, 1, 0);
        vecs[25] = mk(0, 0, 0, 0, 1, 16'h0, 16'h0,    16'h0D01, 0, 0, 1, 0);
        vecs[26] = mk(0, 0, 0, 0, 1, 16'h0, 16'h0,    16'h0C01, 0, 0, 1, 0);
        vecs[27] = mk(0, 0, 0, 0, 1, 16'h0, 16'h0,    16'h0B01, 1, 0, 1, 0);
        vecs[28] = mk(0, 0, 0, 0, 1, 16'h0, 16'h0,    16'h0B02, 1, 0, 1, 1);
        vecs[29] = mk(0, 0, 0, 1, 0, 16'h0, 16'h0500, 16'h0500, 0, 0, 1, 1);
        vecs[30] = mk(1, 0, 1, 1, 0, 16'h0600, 16'h0800, 16'h0600, 0, 0, 1, 1);
        vecs[31] = mk(0, 0, 1, 1, 0, 16'h0, 16'h0900, 16'h0900, 0, 0, 1, 1);
        vecs[32] = mk(0, 0, 0, 1, 1, 16'h0, 16'h0C00, 16'h0C00, 0, 0, 1, 1);
        vecs[33] = mk(0, 0, 0, 0, 1, 16'h0, 16'h0,    16'h0901, 0, 0, 1, 1);
        vecs[34] = mk(0, 0, 0, 0, 1, 16'h0, 16'h0,    16'h0B03, 1, 0, 1, 1);
        vecs[35] = mk(1, 1, 0, 0, 1, 16'h0123, 16'h0, 16'h0123, 1, 0, 1, 1);

        // Reset state, then release away from the clock edge.
        #12;
        checkOutput("reset", 16'h0100, 1, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("first_edge", 16'h0101, 1, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkOutput("re_reset", 16'h0100, 1, 0, 0, 0);

        // Directed vector table.
        for (int i = 0; i < 36; i++) begin
            applyStimulus(vecs[i].fl, vecs[i].st, vecs[i].jp, vecs[i].cl, vecs[i].rt,
                          vecs[i].ft, vecs[i].tg);
            checkOutput($sformatf("vec%0d", i), vecs[i].pc, vecs[i].em, vecs[i].fu,
                        vecs[i].ov, vecs[i].un);
        end

        // Async reset mid-stack: contents vanish between edges.
        applyStimulus(0, 0, 0, 1, 0, 16'h0, 16'h0700);
        applyStimulus(0, 0, 0, 1, 0, 16'h0, 16'h0800);
        checkOutput("two_calls", 16'h0800, 0, 0, 1, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset", 16'h0100, 1, 0, 0, 0);
        reset_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 16'h0, 16'h0);
        checkOutput("ret_after_reset", 16'h0101, 1, 0, 0, 1);

        // Randomized traffic against the model, from a fresh reset.
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        mPc = 16'h0100;
        mRas.delete();
        mOvf = 1'b0;
        mUnf = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic fl, st, jp, cl, rt;
            logic [15:0] ft, tg;
            fl = ($urandom_range(15) == 0);
            st = ($urandom_range(7) == 0);
            jp = ($urandom_range(7) == 0);
            cl = ($urandom_range(4) == 0);
            rt = ($urandom_range(3) == 0);
            ft = 16'($urandom);
            tg = ($urandom_range(3) == 0) ? 16'hFFF0 + 16'($urandom_range(15)) : 16'($urandom);
            applyStimulus(fl, st, jp, cl, rt, ft, tg);
            modelStep(fl, st, jp, cl, rt, ft, tg);
            checkOutput($sformatf("rand%0d", n), mPc, mRas.size() == 0, mRas.size() == 4,
                        mOvf, mUnf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined RISC core's fetch stage. It holds the registered fetch address and advances it by a fixed increment each cycle, with support for stalls, absolute jumps, pipeline-flush redirects and call/return. Call/return is handled by a small circular return-address stack (RAS). It drives the instruction-memory address and reports stack status to the hazard/exception logic.

## Interface
- WIDTH, 16: address width in bits
- RESET_VECTOR, 0: pc_out value after reset
- INC, 1: sequential increment, added modulo 2^WIDTH
- RAS_DEPTH, 4: return-address stack entries, ≥2, power of two
- clock  input  1  rising-edge clock for all state
- reset_n  input  1  reset, asynchronous and active-low
- stall  input  1  hold pc_out and RAS unchanged (ignored when flush=1)
- flush  input  1  redirect from a later stage; highest priority
- flush_target  input  WIDTH  address loaded on flush
- jump  input  1  absolute jump to target
- call  input  1  push pc_out+INC, load target
- ret  input  1  pop RAS top into pc_out
- target  input  WIDTH  destination for jump/call
- pc_out  output  WIDTH  current fetch address (registered)
- pc_seq  output  WIDTH  pc_out+INC, combinational
- ras_empty  output  1  RAS count = 0
- ras_full  output  1  RAS count = RAS_DEPTH
- ras_overflow  output  1  sticky: a push occurred while full
- ras_underflow  output  1  sticky: a ret occurred while empty

## Operation
- State: pc register, RAS array, top pointer (log2 RAS_DEPTH bits, wraps), count (0..RAS_DEPTH), two sticky flags.
- Per rising edge, the first matching row applies; lower-priority requests in the same cycle are discarded:
  - flush: pc ← flush_target. RAS untouched. Applies even if stall=1.
  - stall: all state holds.
  - jump: pc ← target.
  - call: pc ← target. Push pc_seq: top ← top+1 (mod depth), entry[top+1] ← pc_seq, count ← min(count+1, RAS_DEPTH).
    - If count was full, the oldest entry is overwritten and ras_overflow ← 1.
  - ret with count>0: pc ← entry[top], top ← top−1 (mod depth), count ← count−1.
  - ret with count=0: pc ← pc_seq, ras_underflow ← 1, pointer unchanged.
  - none: pc ← pc_seq.
- Arithmetic: pc_seq = (pc_out + INC) truncated to WIDTH. 2^WIDTH−1 with INC=1 wraps to 0.
- Sticky flags clear only on reset.

## Timing
- Reset (reset_n=0, asynchronous assert): pc_out=RESET_VECTOR, count=0, top=0, ras_empty=1, ras_full=0, both flags 0.
  - Held while reset_n=0.
  - First update occurs at the first rising edge after deassertion.
- Reset mid-operation discards all RAS contents immediately.
- Latency: a control input sampled at edge N is visible on pc_out after edge N; pc_seq follows pc_out combinationally.
- ras_empty/ras_full/flags are registered state; they update on the same edge as the push/pop.
- No handshake; requests are single-cycle pulses and are lost if stall=1 and flush=0.

## Test plan
- Reset/sequential: RESET_VECTOR=0x0100, release reset, 4 idle edges -> pc_out 0x0100,0x0101,0x0102,0x0103,0x0104; flags 0, ras_empty=1.
- Wrap/stall: load 0xFFFE by jump, idle 2 edges -> 0xFFFF then 0x0000; assert stall 3 edges -> holds 0x0000; stall+flush to 0x0040 -> 0x0040.
- Call/return: at pc 0x0010 call target 0x0200, at 0x0202 call 0x0300, then ret, ret -> pc 0x0200, 0x0300, 0x0203, 0x0011; ras_empty=1 at end.
- Overflow: 5 consecutive calls (depth 4) from pc values A..E -> ras_full=1, ras_overflow=1; 4 rets return E+1,D+1,C+1,B+1; a 5th ret -> pc_seq, ras_underflow=1.
- Priority: flush+jump+call same edge -> pc=flush_target, count unchanged; jump+call -> pc=target, no push; call+ret -> push occurs, no pop.
- Async reset mid-stack: after 2 calls, pulse reset_n low between edges -> pc_out=RESET_VECTOR and ras_empty=1 immediately; a following ret sets ras_underflow.
